// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and the receiver state encoding for the
//                UART receive path (uart_rx_fifo and its FIFO).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Oversampling ratio and the tick on which the start bit is re-checked.
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    // Payload bits per character.
    localparam int DATA_BITS  = 8;

    // Receiver state machine encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock show-ahead FIFO. The head entry is always
//                presented on o_head (zero while empty). Pointers carry one
//                extra wrap bit to tell full from empty.
//  Ports       : clk, rst_n (async, active-low)
//                i_push/i_data - write request and data
//                i_pop         - read request (ignored while empty)
//                o_head        - head entry
//                o_full/o_empty/o_level - status
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]) &&
                     (r_wr_ptr[c_aw]     != r_rd_ptr[c_aw]);

    // A pop frees a slot in the same cycle, so a full FIFO can still take a
    // push alongside it. A pop while empty is simply ignored.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_level = r_wr_ptr - r_rd_ptr;

    // Gated so the head reads as zero after reset and whenever empty.
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : 8N1 UART receiver (16x oversampling) feeding a show-ahead
//                receive FIFO with a valid/ready read port and sticky
//                frame/overrun error flags.
//  Ports       : clk, reset (async, active-low), rx (raw serial input)
//                rd_data/rd_valid/rd_ready - FIFO read handshake
//                clr_err                   - clears frame_err and overrun
//                frame_err, overrun        - sticky error flags
//                level                     - FIFO occupancy
//  Options     : UART_RX_PARITY_EN - adds an even-parity bit after the data
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = 651,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    input  logic                          clr_err,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int c_tick_w = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int c_os_w   = $clog2(OVERSAMPLE);
    localparam int c_bit_w  = $clog2(DATA_BITS);

    logic                  r_rx_meta;
    logic                  r_rx_sync;
    logic                  r_rx_prev;
    logic [c_tick_w-1:0]   r_tick_cnt;
    logic [c_os_w-1:0]     r_os_cnt;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    rx_state_t             r_state;
    rx_state_t             w_state_nxt;
    logic                  r_frame_err;
    logic                  r_overrun;

    logic w_tick;
    logic w_fall;
    logic w_mid_bit;
    logic w_full_bit;
    logic w_start_det;
    logic w_bit_sample;
    logic w_push;
    logic w_frame_evt;
    logic w_overrun_evt;
    logic w_par_ok;
    logic w_pop;
    logic w_fifo_full;
    logic w_fifo_empty;

    // ------------------------------------------------------------------
    // Input synchronizer; idles high so reset never fakes a start edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall = r_rx_prev && !r_rx_sync;

    // ------------------------------------------------------------------
    // Oversample tick generator, realigned to the start edge.
    // ------------------------------------------------------------------
    assign w_tick = (r_tick_cnt == c_tick_w'(CLKS_PER_TICK - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_start_det || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_mid_bit  = w_tick && (r_os_cnt == c_os_w'(MID_SAMPLE - 1));
    assign w_full_bit = w_tick && (r_os_cnt == c_os_w'(OVERSAMPLE - 1));

    // Tick count within a bit. Cleared at mid-start so every later sample
    // lands 16 ticks apart at the centre of each bit; wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_os_cnt <= '0;
        end else if (w_start_det || (r_state == START && w_mid_bit)) begin
            r_os_cnt <= '0;
        end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Data path: LSB-first shift register and bit counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (w_start_det) begin
                r_bit_cnt <= '0;
            end else if (w_bit_sample) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_bit_sample) begin
                r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_err;

    // Even parity: the parity bit must equal the XOR of the data bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par_err <= 1'b0;
        end else if (w_start_det) begin
            r_par_err <= 1'b0;
        end else if (r_state == PARITY && w_full_bit) begin
            r_par_err <= r_rx_sync ^ (^r_shift);
        end
    end

    assign w_par_ok = !r_par_err;
`else
    assign w_par_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_det  = 1'b0;
        w_bit_sample = 1'b0;
        w_push       = 1'b0;
        w_frame_evt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_start_det = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                // A high line at mid-start means the edge was a glitch.
                if (w_mid_bit) begin
                    w_state_nxt = r_rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_full_bit) begin
                    w_bit_sample = 1'b1;
                    if (r_bit_cnt == c_bit_w'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_full_bit) begin
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (w_full_bit) begin
                    w_state_nxt = IDLE;
                    if (r_rx_sync && w_par_ok) begin
                        w_push = 1'b1;
                    end else begin
                        w_frame_evt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    assign w_pop = rd_ready;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_head  (rd_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (level)
    );

    assign rd_valid = !w_fifo_empty;

    // A full FIFO only loses the byte if nothing is leaving this cycle.
    assign w_overrun_evt = w_push && w_fifo_full && !w_pop;

    // ------------------------------------------------------------------
    // Sticky error flags; a new event wins over a simultaneous clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_frame_evt) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
            if (w_overrun_evt) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule : uart_rx_fifo
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte-oriented UART receiver with an on-chip receive FIFO. It sits directly upstream of the CPU communication controller: it samples the raw `rx` pin, deframes 8N1 characters, and buffers received bytes. The controller consumes the bytes through a valid/ready handshake, so slow command parsing never drops characters during program download.

## Interface
Parameters:
- `CLKS_PER_TICK`, default 651: system clocks per 16x-oversample tick (100 MHz / (9600 × 16)). Legal range is ≥2.
- `FIFO_DEPTH`, default 16: number of entries. Must be a power of two, ≥2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  raw serial input, asynchronous to `clk`. Idles high.
- `rd_data`  out  8  byte at the FIFO head. Only meaningful while `rd_valid` is high.
- `rd_valid`  out  1  FIFO not empty.
- `rd_ready`  in  1  consumer accepts `rd_data`. A pop occurs when `rd_valid && rd_ready`.
- `clr_err`  in  1  synchronous pulse that clears the sticky error flags.
- `frame_err`  out  1  sticky flag: a stop bit was sampled low.
- `overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- `rx` passes through a 2-flop synchronizer. The synchronizer reset value is 1.
- The tick counter counts 0..CLKS_PER_TICK-1 and emits a 1-cycle `tick` at terminal count.
  - It is forced to 0 on start detection so that sampling aligns to the falling edge.
- Receiver FSM (package enum), states IDLE, START, DATA, PARITY (only with the macro), STOP:
  - **IDLE**: a falling edge on synced rx goes to START and clears the tick counter and the oversample count.
  - **START**: after 8 ticks (mid-bit), if rx=0 go to DATA; if rx=1 it was a glitch, return to IDLE with nothing pushed.
  - **DATA**: sample every 16 ticks into a shift register, LSB first. After the 8th bit go to STOP (or PARITY).
  - **STOP**: sample after 16 ticks.
    - If rx=1, push the byte.
    - If rx=0, set `frame_err` and discard the byte.
    - In both cases return to IDLE immediately after the sample. IDLE can detect a new start edge from the next cycle.
- FIFO behaviour:
  - Show-ahead: `rd_data` is always the head entry, taken from a registered read pointer.
  - Push while full without a simultaneous pop: the byte is dropped and `overrun` is set.
  - Push and pop in the same cycle while full: both are accepted and `level` is unchanged.
  - Push and pop in the same cycle while empty: only the push takes effect. The new byte is not bypassed to `rd_data` that cycle.
  - Pointers carry one extra wrap bit. Full is defined as equal index bits with differing wrap bits.
- Error flags:
  - `clr_err` clears both flags.
  - If `clr_err` and a new error event occur in the same cycle, the flag stays set.
- Reset (async, any time, including mid-frame):
  - FSM returns to IDLE; counters and pointers go to 0.
  - `rd_valid`=0, `level`=0, `frame_err`=0, `overrun`=0, `rd_data`=0.
  - A partially received frame is discarded.

## Timing
- Push takes place on the clock edge after the stop-bit sample tick.
- `rd_valid` and `level` update on that same edge, i.e. 1 cycle after the stop sample.
- On a pop, `rd_data` and `rd_valid` reflect the new head on the following cycle.
- One frame lasts 160 ticks (176 with parity).
- Sustained back-to-back frames at line rate must never overrun while the consumer pops at least one byte per frame time.

## Configuration
- `UART_RX_PARITY_EN`:
  - **Defined**: the PARITY state samples a 9th (even-parity) bit. A mismatch discards the byte and sets `frame_err`.
  - **Undefined**: plain 8N1 with no PARITY state; a 9th bit is treated as the stop bit.

## Structure
- Package `uart_pkg` holds:
  - the receiver state enum;
  - `OVERSAMPLE`=16 and `MID_SAMPLE`=8;
  - the `DATA_BITS`=8 localparam.
- Sub-module `sync_fifo` is parameterised by width and depth. It exposes push, pop, full, empty, level and head data, and is instantiated once.

## Test plan
All scenarios use `CLKS_PER_TICK`=4, so one bit = 64 clocks.
- **Reset mid-frame**: assert `reset` low during bit 3 of 0xA5, then send 0x3C → exactly one byte 0x3C read, no error flags.
- **Single byte**: send 0x55 with `rd_ready`=0 → `rd_valid`=1 and `rd_data`=0x55 one cycle after the stop sample; `level`=1.
- **Glitch rejection**: drive a 20-clock low pulse on `rx` → no push; FSM back in IDLE; `level`=0.
- **Framing error**: send 0x81 with the stop bit held low → no push, `frame_err`=1; pulse `clr_err` → `frame_err`=0.
- **Overrun**: send 17 bytes (0x00..0x10) with `rd_ready`=0 → `level`=16, `overrun`=1; draining yields 0x00..0x0F in order.
- **Full FIFO, simultaneous push/pop**: keep `rd_ready`=1 on the stop-sample cycle while full → byte accepted, `level` stays 16, `overrun` stays 0.
